if_id_pipe: RTL and testbench

//  Parametrised IF->ID pipeline stage with valid/ready handshake, flush and hold.

---
 rtl/if_id_pipe_pkg.sv | 23 ++
 rtl/if_id_pipe_skid_buf.sv | 51 +++++
 rtl/if_id_pipe.sv | 146 ++++++++++++++
 tb/tb_if_id_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_pipe_pkg.sv
// if_id_pipe_pkg: shared widths, NOP encoding and default-width beat type for the IF->ID stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_id_pipe_pkg;

  localparam int unsigned DEF_INST_W     = 32;
  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_INT_W      = 8;
  localparam int unsigned DEF_HOLD_W     = 3;
  localparam int unsigned DEF_HOLD_LEVEL = 1;

  // addi x0,x0,0 -- the bubble decode sees whenever the stage is empty
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [7:0]  INT_NONE = 8'h00;

  // One fetched beat at the default widths, ordered as it is packed on the payload bus
  typedef struct packed {
    logic [7:0]  int_flag;
    logic [31:0] addr;
    logic [31:0] inst;
  } beat_t;

endpackage

// File: rtl/if_id_pipe_skid_buf.sv
// pipe_skid_buf: one-entry skid register with flush, holds a beat that arrived while the output was stalled.
// Latency: data written on push is visible on dat_o the following cycle.
// Backpressure: none internally; the owner only pushes when vld_o is low or popping in the same cycle.
// Ports: clk, rst (sync, active-high), flush_i (empties entry), push_i/pop_i, dat_i[W], vld_o, dat_o[W].
// Only elaborated when PIPE_SKID_EN is defined; the default build has no skid entry.
`ifdef PIPE_SKID_EN
module pipe_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] dat_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (push_i) begin
      vld_d = 1'b1;
      dat_d = dat_i;
    end else if (pop_i) begin
      vld_d = 1'b0;
    end
    if (flush_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule
`endif

// File: rtl/if_id_pipe.sv
// if_id_pipe: IF->ID pipeline register carrying instruction, PC and interrupt flags; NOP bubble on flush.
// Latency: 1 cycle through an empty stage.
// Backpressure: valid/ready; hold_flag_i >= HOLD_LEVEL stalls like ready_i=0; flush overrides everything.
// Ports: clk, rst (sync, active-high); upstream valid_i/ready_o/inst_i/inst_addr_i/int_flag_i;
//        control flush_i, hold_flag_i; downstream valid_o/ready_i/inst_o/inst_addr_o/int_flag_o.
// Build option PIPE_SKID_EN: adds a skid entry so ready_o is registered (no ready_i->ready_o path).
module if_id_pipe
  import if_id_pipe_pkg::*;
#(
  parameter int unsigned       INST_W     = DEF_INST_W,
  parameter int unsigned       ADDR_W     = DEF_ADDR_W,
  parameter int unsigned       INT_W      = DEF_INT_W,
  parameter int unsigned       HOLD_W     = DEF_HOLD_W,
  parameter int unsigned       HOLD_LEVEL = DEF_HOLD_LEVEL,
  parameter logic [INST_W-1:0] NOP_INST   = INST_W'(INST_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic [INT_W-1:0]  int_flag_i,
  input  logic              flush_i,
  input  logic [HOLD_W-1:0] hold_flag_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [INT_W-1:0]  int_flag_o
);

  localparam int unsigned       PW       = INT_W + ADDR_W + INST_W;
  localparam logic [HOLD_W-1:0] HOLD_LVL = HOLD_W'(HOLD_LEVEL);

  logic              hold_en, ready_eff, in_fire, out_fire;
  logic [PW-1:0]     in_pay;

  logic              valid_q, valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [INT_W-1:0]  int_q, int_d;

  assign hold_en   = (hold_flag_i >= HOLD_LVL);
  assign ready_eff = ready_i & ~hold_en;
  assign out_fire  = valid_q & ready_eff;
  // A beat offered during flush is dropped, so it never counts as accepted
  assign in_fire   = valid_i & ready_o & ~flush_i;
  assign in_pay    = {int_flag_i, inst_addr_i, inst_i};

`ifdef PIPE_SKID_EN
  logic          skid_vld, skid_push, skid_pop, out_free;
  logic [PW-1:0] skid_dat;

  // Output register can take a new beat this cycle
  assign out_free  = ~valid_q | out_fire;
  // Skid only ever holds a beat behind an occupied output, so it drains first
  assign skid_pop  = skid_vld & out_free;
  assign skid_push = in_fire & ~out_free;

  // Registered ready: depends on skid occupancy, never on ready_i/hold
  assign ready_o = ~rst & (flush_i | ~skid_vld);

  pipe_skid_buf #(
    .W (PW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .dat_i   (in_pay),
    .vld_o   (skid_vld),
    .dat_o   (skid_dat)
  );

  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    addr_d  = addr_q;
    int_d   = int_q;
    if (out_free) begin
      if (skid_vld) begin
        valid_d = 1'b1;
        {int_d, addr_d, inst_d} = skid_dat;
      end else if (in_fire) begin
        valid_d = 1'b1;
        {int_d, addr_d, inst_d} = in_pay;
      end else begin
        valid_d = 1'b0;
        inst_d  = NOP_INST;
        int_d   = '0;
      end
    end
    if (flush_i) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
      int_d   = '0;
    end
  end
`else
  // Single entry: accept when empty or when the current beat leaves this cycle
  assign ready_o = ~rst & (flush_i | ~valid_q | ready_eff);

  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    addr_d  = addr_q;
    int_d   = int_q;
    if (in_fire) begin
      valid_d = 1'b1;
      {int_d, addr_d, inst_d} = in_pay;
    end else if (out_fire) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
      int_d   = '0;
    end
    if (flush_i) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
      int_d   = '0;
    end
  end
`endif

  // Address is left alone when the stage empties so decode sees the last PC
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
      addr_q  <= '0;
      int_q   <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      addr_q  <= addr_d;
      int_q   <= int_d;
    end
  end

  assign valid_o     = valid_q;
  assign inst_o      = inst_q;
  assign inst_addr_o = addr_q;
  assign int_flag_o  = int_q;

endmodule

// File: tb/tb_if_id_pipe.sv
// tb_if_id_pipe: self-checking bench for if_id_pipe using a directed table, hand sequences and random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_if_id_pipe;
  import if_id_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_o, flush_i, valid_o, ready_i;
  logic [31:0] inst_i, inst_addr_i, inst_o, inst_addr_o;
  logic [7:0]  int_flag_i, int_flag_o;
  logic [2:0]  hold_flag_i;

  int n_cmp  = 0;
  int n_fail = 0;

  if_id_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .inst_i      (inst_i),
    .inst_addr_i (inst_addr_i),
    .int_flag_i  (int_flag_i),
    .flush_i     (flush_i),
    .hold_flag_i (hold_flag_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .inst_o      (inst_o),
    .inst_addr_o (inst_addr_o),
    .int_flag_o  (int_flag_o)
  );

  always #5 clk = ~clk;

`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  // Reference model: the stage is an ordered queue of at most CAP beats; head is what decode sees
  beat_t       mq[$];
  logic [31:0] m_last_addr = 32'h0;

  function automatic logic m_hold();
    return hold_flag_i >= 3'(DEF_HOLD_LEVEL);
  endfunction

  function automatic logic m_ready();
    if (rst) return 1'b0;
    if (flush_i) return 1'b1;
    if (CAP == 2) return mq.size() < 2;
    return (mq.size() == 0) || (ready_i && !m_hold());
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against model mid-cycle, away from the active edge
  task automatic chk_phase();
    logic        ev;
    beat_t       hd;
    @(negedge clk);
    ev = (mq.size() > 0);
    hd = ev ? mq[0] : '0;
    chk("m_valid", 32'(valid_o), 32'(ev));
    chk("m_inst", inst_o, ev ? hd.inst : INST_NOP);
    chk("m_int", 32'(int_flag_o), ev ? 32'(hd.int_flag) : 32'(INT_NONE));
    chk("m_addr", inst_addr_o, ev ? hd.addr : m_last_addr);
    chk("m_ready", 32'(ready_o), 32'(m_ready()));
  endtask

  task automatic edge_phase();
    logic rdy, ofire, ifire;
    @(posedge clk);
    rdy = m_ready();
    if (rst) begin
      mq.delete();
      m_last_addr = 32'h0;
    end else if (flush_i) begin
      mq.delete();
    end else begin
      ofire = (mq.size() > 0) && ready_i && !m_hold();
      ifire = valid_i && rdy;
      if (ofire) void'(mq.pop_front());
      if (ifire) mq.push_back('{int_flag: int_flag_i, addr: inst_addr_i, inst: inst_i});
      if (mq.size() > CAP) begin
        n_cmp++;
        n_fail++;
        $display("FAIL model_overflow: got %0d entries allowed %0d", mq.size(), CAP);
      end
    end
    if (mq.size() > 0) m_last_addr = mq[0].addr;
    #1;
  endtask

  task automatic cycle();
    chk_phase();
    edge_phase();
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; inst_i = 32'h0; inst_addr_i = 32'h0; int_flag_i = 8'h0;
    flush_i = 1'b0; hold_flag_i = 3'd0; ready_i = 1'b1;
  endtask

  typedef struct {
    logic        vi;
    logic [31:0] inst;
    logic [31:0] addr;
    logic [7:0]  intf;
    logic        fl;
    logic [2:0]  hold;
    logic        ri;
    logic        ev;
    logic [31:0] einst;
    logic [7:0]  eint;
    logic        erdy_1;
    logic        erdy_2;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // inputs for this cycle                              | outputs seen this cycle (ready: 1-entry, skid)
    tbl[0]  = '{1'b1, 32'h100, 32'h00, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 32'h13,  8'h00, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 32'h101, 32'h04, 8'h01, 1'b0, 3'd0, 1'b1, 1'b1, 32'h100, 8'h00, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 32'h102, 32'h08, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 32'h101, 8'h01, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 32'h0,   32'h00, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 32'h102, 8'h00, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 32'h0,   32'h00, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 32'h13,  8'h00, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 32'h200, 32'h40, 8'h80, 1'b0, 3'd0, 1'b0, 1'b0, 32'h13,  8'h00, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 32'h201, 32'h44, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 32'h200, 8'h80, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 32'h201, 32'h44, 8'h00, 1'b0, 3'd1, 1'b1, 1'b1, 32'h200, 8'h80, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 32'h202, 32'h48, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 32'h200, 8'h80, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 32'h0,   32'h00, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 32'h13,  8'h00, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 32'h0,   32'h00, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 32'h13,  8'h00, 1'b1, 1'b1};

    // Reset: two cycles with a beat offered, which must be ignored
    idle_inputs();
    rst = 1'b1;
    valid_i = 1'b1; inst_i = 32'hDEAD_BEEF; inst_addr_i = 32'h1234; int_flag_i = 8'hFF;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk_phase();
      chk("rst_valid", 32'(valid_o), 32'h0);
      chk("rst_inst", inst_o, 32'h13);
      chk("rst_ready", 32'(ready_o), 32'h0);
      chk("rst_addr", inst_addr_o, 32'h0);
      edge_phase();
    end
    idle_inputs();
    rst = 1'b0;
    chk_phase();
    chk("rst_release_ready", 32'(ready_o), 32'h1);
    chk("rst_release_valid", 32'(valid_o), 32'h0);
    edge_phase();

    // Directed table
    for (int r = 0; r < 11; r++) begin
      valid_i = tbl[r].vi; inst_i = tbl[r].inst; inst_addr_i = tbl[r].addr;
      int_flag_i = tbl[r].intf; flush_i = tbl[r].fl; hold_flag_i = tbl[r].hold; ready_i = tbl[r].ri;
      chk_phase();
      chk($sformatf("tbl%0d_valid", r), 32'(valid_o), 32'(tbl[r].ev));
      chk($sformatf("tbl%0d_inst", r), inst_o, tbl[r].einst);
      chk($sformatf("tbl%0d_int", r), 32'(int_flag_o), 32'(tbl[r].eint));
      chk($sformatf("tbl%0d_ready", r), 32'(ready_o), 32'((CAP == 2) ? tbl[r].erdy_2 : tbl[r].erdy_1));
      edge_phase();
    end
    idle_inputs();

    // Streaming: 8 beats back to back, each emerges one cycle later with no gaps
    for (int k = 0; k <= 8; k++) begin
      valid_i = (k < 8); inst_i = 32'h100 + 32'(k); inst_addr_i = 32'(4 * k); ready_i = 1'b1;
      chk_phase();
      chk("stream_valid", 32'(valid_o), 32'(k > 0));
      if (k > 0) begin
        chk("stream_inst", inst_o, 32'h100 + 32'(k - 1));
        chk("stream_addr", inst_addr_o, 32'(4 * (k - 1)));
      end
      edge_phase();
    end
    idle_inputs();
    cycle();

    // Backpressure then hold mid-stream; upstream keeps a beat until it is accepted
    begin
      int k = 0;
      for (int c = 0; c < 30; c++) begin
        valid_i     = (k < 10);
        inst_i      = 32'h300 + 32'(k);
        inst_addr_i = 32'h800 + 32'(4 * k);
        int_flag_i  = (k == 5) ? 8'h01 : 8'h00;
        ready_i     = !(c >= 3 && c < 6);
        hold_flag_i = (c >= 10 && c < 13) ? 3'(DEF_HOLD_LEVEL) : 3'd0;
        chk_phase();
        edge_phase();
        if (valid_i && (m_ready() || 1'b1) && mq.size() > 0 && mq[mq.size()-1].inst == inst_i) k++;
      end
    end
    idle_inputs();

    // Flush while full, stalled and offered a beat
    valid_i = 1'b1; inst_i = 32'h500; ready_i = 1'b0; cycle();
    inst_i = 32'h501; cycle();
    inst_i = 32'h502; cycle();
    inst_i = 32'h503; flush_i = 1'b1; cycle();
    idle_inputs();
    chk_phase();
    chk("flush_valid", 32'(valid_o), 32'h0);
    chk("flush_inst", inst_o, 32'h13);
    chk("flush_int", 32'(int_flag_o), 32'h0);
    edge_phase();
    for (int i = 0; i < 3; i++) begin
      chk_phase();
      chk("flush_no_reemerge", 32'(valid_o), 32'h0);
      edge_phase();
    end

    // Random traffic against the queue model
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 199) == 0);
      valid_i     = ($urandom_range(0, 9) < 7);
      inst_i      = $urandom;
      inst_addr_i = $urandom;
      int_flag_i  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      flush_i     = ($urandom_range(0, 29) == 0);
      hold_flag_i = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      ready_i     = ($urandom_range(0, 9) < 6);
      cycle();
    end
    rst = 1'b0;
    idle_inputs();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
